req_arbiter8: RTL and testbench

- Arbitrates one shared resource between 8 requesters (index 0..7) and issues a single registered grant.
- Two policies, selectable at run time:
  - Fixed priority: index 0 highest, index 7 lowest.
  - Round-robin: rotating priority.
- Bounds each ownership with a watchdog hold counter.
- Sits in front of the shared datapath; owner index is exported for steering muxes.

---
 rtl/req_arbiter8_if.sv | 31 +++
 rtl/req_arbiter8.sv | 126 ++++++++++++
 tb/tb_req_arbiter8.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/req_arbiter8_if.sv
// Arbiter bus: request/release inputs and registered grant outputs.
//   en          arbitration enable
//   rr_mode     0 = fixed priority, 1 = round-robin
//   req[7:0]    level requests, held until granted
//   done        owner release strobe
//   grant[7:0]  one-hot grant
//   grant_idx   binary owner index (holds last owner when idle)
//   grant_valid grant held
//   none        idle, enabled and nothing requested
//   timeout     one-cycle pulse on forced release
interface req_arbiter8_if;
  logic       en;
  logic       rr_mode;
  logic [7:0] req;
  logic       done;
  logic [7:0] grant;
  logic [2:0] grant_idx;
  logic       grant_valid;
  logic       none;
  logic       timeout;

  modport master (
    output en, rr_mode, req, done,
    input  grant, grant_idx, grant_valid, none, timeout
  );

  modport slave (
    input  en, rr_mode, req, done,
    output grant, grant_idx, grant_valid, none, timeout
  );
endinterface

// File: rtl/req_arbiter8.sv
// 8-way arbiter with fixed-priority / round-robin selection and a hold watchdog.
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   io_arb arbiter bus (slave side), see req_arbiter8_if
module req_arbiter8 #(
  parameter int unsigned MAX_HOLD = 16,
  parameter int unsigned CW       = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  req_arbiter8_if.slave      io_arb
);

  localparam int unsigned N  = 8;
  localparam int unsigned IW = 3;

  typedef enum logic {S_IDLE, S_GRANT} state_t;

  state_t          r_state;
  logic [N-1:0]    r_grant;
  logic [IW-1:0]   r_grant_idx;
  logic            r_grant_valid;
  logic            r_none;
  logic            r_timeout;
  logic [CW-1:0]   r_cnt;
  logic [IW-1:0]   r_ptr;

  state_t          w_state;
  logic [N-1:0]    w_grant;
  logic [IW-1:0]   w_grant_idx;
  logic            w_grant_valid;
  logic            w_none;
  logic            w_timeout;
  logic [CW-1:0]   w_cnt;
  logic [IW-1:0]   w_ptr;

  logic [IW-1:0]   w_win;
  logic [IW-1:0]   w_scan;
  logic            w_any_req;
  logic            w_expire;
  logic            w_owner_req;

  // Winner select: scan downward so the lowest offset from the start point wins.
  always_comb begin
    w_win  = '0;
    w_scan = '0;
    for (int k = N - 1; k >= 0; k--) begin
      w_scan = io_arb.rr_mode ? IW'(r_ptr + IW'(k)) : IW'(k);
      if (io_arb.req[w_scan]) begin
        w_win = w_scan;
      end
    end
  end

  assign w_any_req   = |io_arb.req;
  assign w_expire    = (r_cnt == CW'(MAX_HOLD - 1));
  assign w_owner_req = io_arb.req[r_grant_idx];

  // Next-state and registered-output values.
  always_comb begin
    w_state       = r_state;
    w_grant       = r_grant;
    w_grant_idx   = r_grant_idx;
    w_grant_valid = r_grant_valid;
    w_none        = 1'b0;
    w_timeout     = 1'b0;
    w_cnt         = r_cnt;
    w_ptr         = r_ptr;
    case (r_state)
      S_IDLE: begin
        w_none = io_arb.en & ~w_any_req;
        if (io_arb.en && w_any_req) begin
          w_state       = S_GRANT;
          w_grant       = N'(1) << w_win;
          w_grant_idx   = w_win;
          w_grant_valid = 1'b1;
          w_cnt         = '0;
        end
      end
      S_GRANT: begin
        if (io_arb.done || !w_owner_req || w_expire) begin
          w_state       = S_IDLE;
          w_grant       = '0;
          w_grant_valid = 1'b0;
          w_cnt         = '0;
          w_ptr         = IW'(r_grant_idx + IW'(1));
          // Only a pure watchdog expiry counts as a forced release.
          w_timeout     = ~io_arb.done & w_owner_req;
        end else begin
          w_cnt = CW'(r_cnt + CW'(1));
        end
      end
      default: w_state = S_IDLE;
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= S_IDLE;
      r_grant       <= '0;
      r_grant_idx   <= '0;
      r_grant_valid <= 1'b0;
      r_none        <= 1'b0;
      r_timeout     <= 1'b0;
      r_cnt         <= '0;
      r_ptr         <= '0;
    end else begin
      r_state       <= w_state;
      r_grant       <= w_grant;
      r_grant_idx   <= w_grant_idx;
      r_grant_valid <= w_grant_valid;
      r_none        <= w_none;
      r_timeout     <= w_timeout;
      r_cnt         <= w_cnt;
      r_ptr         <= w_ptr;
    end
  end

  assign io_arb.grant       = r_grant;
  assign io_arb.grant_idx   = r_grant_idx;
  assign io_arb.grant_valid = r_grant_valid;
  assign io_arb.none        = r_none;
  assign io_arb.timeout     = r_timeout;

endmodule

// File: tb/tb_req_arbiter8.sv
// Directed bench for req_arbiter8 (MAX_HOLD=16).
module tb_req_arbiter8;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  req_arbiter8_if arb ();

  req_arbiter8 #(.MAX_HOLD(16), .CW(8)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .io_arb (arb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks      = 0;
    failures    = 0;
    rst_n       = 1'b0;
    arb.en      = 1'b0;
    arb.rr_mode = 1'b0;
    arb.req     = 8'h00;
    arb.done    = 1'b0;
    tick();
    tick();

    // Reset state
    check("rst_grant", 32'(arb.grant), 32'h00);
    check("rst_idx", 32'(arb.grant_idx), 32'd0);
    check("rst_valid", 32'(arb.grant_valid), 32'd0);
    check("rst_none", 32'(arb.none), 32'd0);
    check("rst_timeout", 32'(arb.timeout), 32'd0);

    // Fixed priority: lowest set index wins, re-wins after one idle cycle
    @(negedge clk);
    rst_n   = 1'b1;
    arb.en  = 1'b1;
    arb.req = 8'b1010_0100;
    tick();
    check("fp_grant", 32'(arb.grant), 32'h04);
    check("fp_idx", 32'(arb.grant_idx), 32'd2);
    check("fp_valid", 32'(arb.grant_valid), 32'd1);
    check("fp_none", 32'(arb.none), 32'd0);
    arb.done = 1'b1;
    tick();
    arb.done = 1'b0;
    check("fp_rel_grant", 32'(arb.grant), 32'h00);
    check("fp_rel_valid", 32'(arb.grant_valid), 32'd0);
    check("fp_rel_timeout", 32'(arb.timeout), 32'd0);
    check("fp_idle_idx", 32'(arb.grant_idx), 32'd2);
    tick();
    check("fp_regrant", 32'(arb.grant), 32'h04);
    arb.req = 8'h00;
    tick();
    check("fp_wd_grant", 32'(arb.grant), 32'h00);

    // Round-robin from ptr=0 (reset) with all requests held
    rst_n = 1'b0;
    #1;
    @(negedge clk);
    rst_n       = 1'b1;
    arb.rr_mode = 1'b1;
    arb.req     = 8'hFF;
    tick();
    for (int i = 0; i < 9; i++) begin
      check("rr_idx", 32'(arb.grant_idx), 32'(i % 8));
      check("rr_grant", 32'(arb.grant), 32'h1 << (i % 8));
      arb.done = 1'b1;
      tick();
      arb.done = 1'b0;
      check("rr_gap", 32'(arb.grant_valid), 32'd0);
      if (i == 8) arb.req = 8'h00;
      tick();
    end
    check("rr_none", 32'(arb.none), 32'd1);
    check("rr_none_grant", 32'(arb.grant), 32'h00);

    // Watchdog: 16 cycles held, then timeout pulse, regrant after one idle cycle
    arb.rr_mode = 1'b0;
    arb.req     = 8'h10;
    tick();
    check("wd_grant", 32'(arb.grant), 32'h10);
    check("wd_t0", 32'(arb.timeout), 32'd0);
    for (int c = 1; c < 16; c++) begin
      tick();
      check("wd_hold", 32'(arb.grant_valid), 32'd1);
      check("wd_no_to", 32'(arb.timeout), 32'd0);
    end
    tick();
    check("wd_rel_valid", 32'(arb.grant_valid), 32'd0);
    check("wd_rel_grant", 32'(arb.grant), 32'h00);
    check("wd_timeout", 32'(arb.timeout), 32'd1);
    check("wd_idle_idx", 32'(arb.grant_idx), 32'd4);
    tick();
    check("wd_regrant", 32'(arb.grant), 32'h10);
    check("wd_to_clear", 32'(arb.timeout), 32'd0);
    arb.req = 8'h00;
    tick();
    check("wd_wd_valid", 32'(arb.grant_valid), 32'd0);
    check("wd_wd_timeout", 32'(arb.timeout), 32'd0);

    // Owner withdraws at cycle 5; next RR scan starts at 4
    arb.rr_mode = 1'b1;
    arb.req     = 8'h08;
    tick();
    check("wd3_grant", 32'(arb.grant), 32'h08);
    check("wd3_idx", 32'(arb.grant_idx), 32'd3);
    for (int c = 2; c <= 5; c++) begin
      tick();
      check("wd3_hold", 32'(arb.grant_valid), 32'd1);
    end
    arb.req = 8'h00;
    tick();
    check("wd3_rel_grant", 32'(arb.grant), 32'h00);
    check("wd3_rel_timeout", 32'(arb.timeout), 32'd0);
    arb.req = 8'hFF;
    tick();
    check("wd3_ptr", 32'(arb.grant_idx), 32'd4);
    check("wd3_ptr_grant", 32'(arb.grant), 32'h10);
    arb.req  = 8'h00;
    arb.done = 1'b1;
    tick();
    arb.done = 1'b0;
    check("wd3_rel2", 32'(arb.grant_valid), 32'd0);

    // Enable gating and none flag
    arb.rr_mode = 1'b0;
    arb.en      = 1'b0;
    arb.req     = 8'h01;
    tick();
    check("en0_grant", 32'(arb.grant), 32'h00);
    check("en0_none", 32'(arb.none), 32'd0);
    arb.done = 1'b1;
    tick();
    arb.done = 1'b0;
    check("en0_grant2", 32'(arb.grant), 32'h00);
    check("en0_none2", 32'(arb.none), 32'd0);
    arb.en = 1'b1;
    tick();
    check("en1_grant", 32'(arb.grant), 32'h01);
    arb.req = 8'h00;
    tick();
    check("en1_rel", 32'(arb.grant_valid), 32'd0);
    check("en1_rel_none", 32'(arb.none), 32'd0);
    tick();
    check("en1_none", 32'(arb.none), 32'd1);

    // Async reset mid-grant clears outputs with no clock edge; ptr back to 0
    arb.req = 8'h40;
    tick();
    check("mr_idx", 32'(arb.grant_idx), 32'd6);
    check("mr_grant", 32'(arb.grant), 32'h40);
    #2;
    rst_n = 1'b0;
    #1;
    check("mr_grant_clr", 32'(arb.grant), 32'h00);
    check("mr_valid_clr", 32'(arb.grant_valid), 32'd0);
    check("mr_timeout_clr", 32'(arb.timeout), 32'd0);
    check("mr_idx_clr", 32'(arb.grant_idx), 32'd0);
    @(negedge clk);
    rst_n       = 1'b1;
    arb.rr_mode = 1'b1;
    arb.req     = 8'hFF;
    tick();
    check("mr_rr_idx", 32'(arb.grant_idx), 32'd0);
    check("mr_rr_grant", 32'(arb.grant), 32'h01);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
